monitor_core_checker: RTL and testbench
=======================================

MONITOR_CORE_CHECKER -- requirements
Module: monitor

Interface
REQ-001 SHALL have parameter NUM_THR, default 4: number of hardware threads observed.
REQ-002 SHALL have parameter TIMEOUT, default 100000: maximum idle cycles allowed without any retirement.
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle and retire counters.
REQ-004 clk  input  1  single monitor clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 diag_done  input  1  boot complete; arms the checker.
REQ-007 thr_active  input  NUM_THR  mask of threads expected to finish.
REQ-008 good_trap  input  NUM_THR  per-thread pass-trap pulse.
REQ-009 bad_trap  input  NUM_THR  per-thread fail-trap pulse.
REQ-010 retire  input  NUM_THR  per-thread instruction-retire pulse.
REQ-011 done  output  1  test has finished, pass or fail.
REQ-012 pass  output  1  test passed.
REQ-013 fail  output  1  test failed; equivalent to fail_flag.
REQ-014 fail_code  output  2  failure cause: 0 none, 1 bad trap, 2 timeout, 3 unexpected thread.
REQ-015 cycle_count  output  CNT_W  number of RUN cycles.
REQ-016 retire_count  output  CNT_W  total instructions retired during RUN.
REQ-017 thr_finished  output  NUM_THR  sticky per-thread good-trap bits.

Function
REQ-018 SHALL implement a four-state FSM with states IDLE, RUN, PASS and FAIL.
REQ-019 IDLE->RUN SHALL occur on the first rising edge where diag_done=1; in IDLE all trap and retire inputs are ignored.
REQ-020 In RUN, cycle_count SHALL increment by 1 per cycle and saturate at all-ones.
REQ-021 In RUN, retire_count SHALL add popcount(retire) each cycle and saturate at all-ones.
REQ-022 In RUN, thr_finished[i] SHALL set when good_trap[i]=1 and thr_active[i]=1, and stay set until rst.
REQ-023 In RUN, any bad_trap bit SHALL cause a transition to FAIL with fail_code=1.
REQ-024 In RUN, good_trap[i]=1 with thr_active[i]=0 SHALL cause a transition to FAIL with fail_code=3.
REQ-025 In RUN, an idle counter SHALL clear on any retire bit and otherwise increment; when it reaches TIMEOUT the FSM SHALL go to FAIL with fail_code=2.
REQ-026 The FSM SHALL go RUN->PASS when (thr_finished | new good traps) covers thr_active and thr_active is nonzero.
REQ-027 If thr_active=0, RUN SHALL never reach PASS; only FAIL or rst end RUN.
REQ-028 Simultaneous events SHALL resolve with priority bad trap (1) > unexpected thread (3) > timeout (2) > pass.
REQ-029 PASS and FAIL SHALL be terminal and sticky until rst; counters freeze and inputs are ignored.
REQ-030 done=1 in PASS or FAIL; pass=1 only in PASS; fail=1 only in FAIL.
REQ-031 All outputs SHALL be registered and reflect an event one cycle after the edge that samples it.
REQ-032 thr_active SHALL be sampled every cycle; the team requires it to be held stable during RUN.

Reset
REQ-033 rst=1 SHALL force IDLE on the next rising edge, whatever the current state, including mid-RUN.
REQ-034 After rst: done=0, pass=0, fail=0, fail_code=0, all counters 0, thr_finished=0.
REQ-035 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-036 rst; diag_done=1; thr_active=4'b0011; good_trap thread0 at cycle 5 and thread1 at cycle 9 -> pass=1, done=1 one cycle after the thread1 trap, thr_finished=2'b11, cycle_count=10.
REQ-037 RUN; good_trap=4'b0001 and bad_trap=4'b0010 in the same cycle -> fail=1, fail_code=1, pass=0.
REQ-038 TIMEOUT=16; RUN with no retire -> fail=1, fail_code=2 after 16 idle cycles; a retire pulse at cycle 10 restarts the count.
REQ-039 thr_active=4'b0001; good_trap=4'b0100 -> fail=1, fail_code=3.
REQ-040 retire=4'b1111 for 3 cycles, then 4'b0101 for 1 cycle -> retire_count=14.
REQ-041 rst asserted during RUN with thr_finished nonzero -> all outputs zero and IDLE; a subsequent diag_done restarts counting from 0.

Source files
------------

// File: rtl/monitor_core_checker.sv
// End-of-test monitor: watches per-thread pass/fail traps and retirement activity,
// and reports a sticky pass/fail verdict with a failure cause and run statistics.
module monitor_core_checker #(
    parameter int NUM_THR = 4,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               diag_done,
    input  logic [NUM_THR-1:0] thr_active,
    input  logic [NUM_THR-1:0] good_trap,
    input  logic [NUM_THR-1:0] bad_trap,
    input  logic [NUM_THR-1:0] retire,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   retire_count,
    output logic [NUM_THR-1:0] thr_finished
);

    // Idle counter only needs to reach TIMEOUT; the FSM leaves RUN at that point.
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_BAD   = 2'd1;
    localparam logic [1:0] CODE_TMO   = 2'd2;
    localparam logic [1:0] CODE_UNEXP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_THR-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_THR; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            return '1;
        end else begin
            return s[CNT_W-1:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [IDLE_W-1:0]  idle_cnt_r;
    logic [IDLE_W-1:0]  idle_next_s;
    logic [CNT_W-1:0]   cycle_cnt_r;
    logic [CNT_W-1:0]   retire_cnt_r;
    logic [NUM_THR-1:0] finished_r;
    logic [NUM_THR-1:0] finished_next_s;
    logic               any_bad_s;
    logic               any_unexp_s;
    logic               timeout_s;
    logic               all_done_s;
    logic [1:0]         code_next_s;
    logic [1:0]         fail_code_r;
    logic               done_r;
    logic               pass_r;
    logic               fail_r;

    // Decode this cycle's trap, timeout and completion events.
    always_comb begin
        any_bad_s       = |bad_trap;
        any_unexp_s     = |(good_trap & ~thr_active);
        finished_next_s = finished_r | (good_trap & thr_active);
        if (|retire) begin
            idle_next_s = '0;
        end else begin
            idle_next_s = idle_cnt_r + IDLE_W'(1);
        end
        timeout_s  = (idle_next_s == TIMEOUT_V);
        // An empty active mask can never complete.
        all_done_s = (|thr_active) && ((finished_next_s & thr_active) == thr_active);
    end

    // Next-state and failure-cause selection; fail causes outrank a pass.
    always_comb begin
        state_s     = state_r;
        code_next_s = fail_code_r;
        case (state_r)
            ST_IDLE: begin
                if (diag_done) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (any_bad_s) begin
                    state_s     = ST_FAIL;
                    code_next_s = CODE_BAD;
                end else if (any_unexp_s) begin
                    state_s     = ST_FAIL;
                    code_next_s = CODE_UNEXP;
                end else if (timeout_s) begin
                    state_s     = ST_FAIL;
                    code_next_s = CODE_TMO;
                end else if (all_done_s) begin
                    state_s     = ST_PASS;
                    code_next_s = CODE_NONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PASS: state_s = ST_PASS;
            ST_FAIL: state_s = ST_FAIL;
            default: begin
                state_s     = ST_IDLE;
                code_next_s = CODE_NONE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run statistics and sticky thread completion; frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r   <= '0;
            cycle_cnt_r  <= '0;
            retire_cnt_r <= '0;
            finished_r   <= '0;
        end else if (state_r == ST_RUN) begin
            idle_cnt_r   <= idle_next_s;
            cycle_cnt_r  <= sat_add(cycle_cnt_r, CNT_W'(1));
            retire_cnt_r <= sat_add(retire_cnt_r, popcount(retire));
            finished_r   <= finished_next_s;
        end else begin
            idle_cnt_r   <= idle_cnt_r;
            cycle_cnt_r  <= cycle_cnt_r;
            retire_cnt_r <= retire_cnt_r;
            finished_r   <= finished_r;
        end
    end

    // Verdict flags registered from the next state so they appear with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_code_r <= CODE_NONE;
        end else begin
            done_r      <= (state_s == ST_PASS) || (state_s == ST_FAIL);
            pass_r      <= (state_s == ST_PASS);
            fail_r      <= (state_s == ST_FAIL);
            fail_code_r <= code_next_s;
        end
    end

    assign done         = done_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign fail_code    = fail_code_r;
    assign cycle_count  = cycle_cnt_r;
    assign retire_count = retire_cnt_r;
    assign thr_finished = finished_r;

endmodule

// File: tb/tb_monitor_core_checker.sv
// Directed bench for monitor_core_checker with hand-computed expectations.
module tb_monitor_core_checker;

    logic        clk;
    logic        rst;
    logic        diag_done;
    logic [3:0]  thr_active;
    logic [3:0]  good_trap;
    logic [3:0]  bad_trap;
    logic [3:0]  retire;
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [3:0]  thr_finished;

    int n_total = 0;
    int n_bad   = 0;

    monitor_core_checker #(.NUM_THR(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .diag_done    (diag_done),
        .thr_active   (thr_active),
        .good_trap    (good_trap),
        .bad_trap     (bad_trap),
        .retire       (retire),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .fail_code    (fail_code),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .thr_finished (thr_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after the edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        diag_done  = 1'b0;
        good_trap  = 4'b0000;
        bad_trap   = 4'b0000;
        retire     = 4'b0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] act);
        thr_active = act;
        diag_done  = 1'b1;
        tick();
        diag_done  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_fail"}, {31'd0, fail}, 32'd0);
        check({tag, "_code"}, {30'd0, fail_code}, 32'd0);
        check({tag, "_cyc"}, cycle_count, 32'd0);
        check({tag, "_ret"}, retire_count, 32'd0);
        check({tag, "_fin"}, {28'd0, thr_finished}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        thr_active = 4'b0000;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        // Traps and retires are ignored while idle.
        retire    = 4'b1111;
        good_trap = 4'b0001;
        bad_trap  = 4'b0001;
        tick();
        clear_inputs();
        check_zero("idle_ignore");

        // Two-thread pass: traps in RUN cycles 5 and 9.
        do_reset();
        start_run(4'b0011);
        check("t1_cyc_start", cycle_count, 32'd0);
        for (int c = 0; c < 10; c++) begin
            good_trap = (c == 5) ? 4'b0001 : ((c == 9) ? 4'b0010 : 4'b0000);
            tick();
            if (c == 8) begin
                check("t1_done_early", {31'd0, done}, 32'd0);
                check("t1_fin_part", {28'd0, thr_finished}, 32'd1);
            end
        end
        good_trap = 4'b0000;
        check("t1_pass", {31'd0, pass}, 32'd1);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_fail", {31'd0, fail}, 32'd0);
        check("t1_fin", {28'd0, thr_finished}, 32'd3);
        check("t1_cyc", cycle_count, 32'd10);
        // PASS is sticky and freezes the counters.
        bad_trap = 4'b0001;
        retire   = 4'b1111;
        tick();
        tick();
        clear_inputs();
        check("t1_sticky_pass", {31'd0, pass}, 32'd1);
        check("t1_sticky_cyc", cycle_count, 32'd10);
        check("t1_sticky_ret", retire_count, 32'd0);

        // Good and bad trap together: bad trap wins.
        do_reset();
        start_run(4'b0011);
        good_trap = 4'b0001;
        bad_trap  = 4'b0010;
        tick();
        clear_inputs();
        check("t2_fail", {31'd0, fail}, 32'd1);
        check("t2_code", {30'd0, fail_code}, 32'd1);
        check("t2_pass", {31'd0, pass}, 32'd0);
        check("t2_done", {31'd0, done}, 32'd1);

        // Unexpected thread.
        do_reset();
        start_run(4'b0001);
        good_trap = 4'b0100;
        tick();
        clear_inputs();
        check("t3_fail", {31'd0, fail}, 32'd1);
        check("t3_code", {30'd0, fail_code}, 32'd3);

        // Bad trap outranks unexpected thread.
        do_reset();
        start_run(4'b0001);
        good_trap = 4'b0100;
        bad_trap  = 4'b0001;
        tick();
        clear_inputs();
        check("t4_code", {30'd0, fail_code}, 32'd1);

        // Timeout with a retire at cycle 10 restarting the idle count.
        do_reset();
        start_run(4'b0001);
        for (int c = 0; c < 11; c++) begin
            retire = (c == 10) ? 4'b0001 : 4'b0000;
            tick();
        end
        retire = 4'b0000;
        check("t5_no_early_tmo", {31'd0, fail}, 32'd0);
        for (int c = 0; c < 15; c++) tick();
        check("t5_fail_at15", {31'd0, fail}, 32'd0);
        tick();
        check("t5_fail", {31'd0, fail}, 32'd1);
        check("t5_code", {30'd0, fail_code}, 32'd2);
        check("t5_cyc", cycle_count, 32'd27);

        // Retire counting, empty-mask no-pass, and reset mid-RUN.
        do_reset();
        start_run(4'b0011);
        retire = 4'b1111;
        for (int c = 0; c < 3; c++) tick();
        retire = 4'b0101;
        tick();
        retire = 4'b0000;
        check("t6_ret", retire_count, 32'd14);
        good_trap = 4'b0001;
        tick();
        good_trap = 4'b0000;
        check("t6_fin", {28'd0, thr_finished}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        rst       = 1'b1;
        diag_done = 1'b1;
        tick();
        rst       = 1'b0;
        diag_done = 1'b0;
        check_zero("t6_rst");
        start_run(4'b0000);
        check("t6_cyc0", cycle_count, 32'd0);
        retire = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        retire = 4'b0000;
        check("t6_cyc5", cycle_count, 32'd5);
        check("t6_nopass", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
